// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   - funct3 encodings for loads and stores (separate enums, values overlap)
//   - FSM state and response error encodings
//   - bit positions inside the 4-bit {funct3, we} memory control word
package lsu_pkg;

   // Memory control word layout: {funct3[2:0], we}
   localparam int MC_WE_BIT  = 0;
   localparam int MC_F3_LSB  = 1;
   localparam int MC_F3_MSB  = 3;

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } load_f3_e;

   typedef enum logic [2:0] {
      F3_SB = 3'b000,
      F3_SH = 3'b001,
      F3_SW = 3'b010
   } store_f3_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_WAIT_R = 2'd2,
      S_RESP   = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_ILLEGAL  = 2'b10,
      ERR_TIMEOUT  = 2'b11
   } lsu_err_e;

endpackage

// File: rtl/lsu_if.sv
// lsu_if: single-outstanding data-memory bus.
//   master (LSU):    drives dmem_req/we/addr/be/wdata, receives gnt/rvalid/rdata
//   slave  (memory): the mirror image
interface lsu_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane logic for the load/store unit.
//   Request side (incoming op):
//     req_funct3, req_we, req_addr_lo, req_wdata -> be, wdata_rep, misaligned, illegal
//   Load side (registered op + returned memory word):
//     ld_funct3, ld_addr_lo, ld_rdata -> ld_data (sign/zero extended)
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  req_funct3,
   input  logic        req_we,
   input  logic [1:0]  req_addr_lo,
   input  logic [31:0] req_wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic        misaligned,
   output logic        illegal,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
      be         = '0;
      wdata_rep  = '0;
      misaligned = 1'b0;

      if (req_we) illegal = !(req_funct3 inside {F3_SB, F3_SH, F3_SW});
      else        illegal = !(req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});

      // Size lives in funct3[1:0] for both loads and stores.
      case (req_funct3[1:0])
         2'b00: begin
            be        = 4'b0001 << req_addr_lo;
            wdata_rep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be         = 4'b0011 << {req_addr_lo[1], 1'b0};
            wdata_rep  = {2{req_wdata[15:0]}};
            misaligned = req_addr_lo[0];
         end
         2'b10: begin
            be         = 4'b1111;
            wdata_rep  = req_wdata;
            misaligned = |req_addr_lo;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (ld_addr_lo)
         2'd0:    byte_sel = ld_rdata[7:0];
         2'd1:    byte_sel = ld_rdata[15:8];
         2'd2:    byte_sel = ld_rdata[23:16];
         default: byte_sel = ld_rdata[31:24];
      endcase
      half_sel = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

      case (ld_funct3)
         F3_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
         F3_LW:   ld_data = ld_rdata;
         F3_LBU:  ld_data = {24'd0, byte_sel};
         F3_LHU:  ld_data = {16'd0, half_sel};
         default: ld_data = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage with a single-outstanding data-memory port.
//   Pipeline side: req_valid/req_ready, mem_ctrl {funct3, we}, is_load, addr,
//                  wdata (rs2), rd_addr
//   Memory side:   dmem (lsu_if.master) request/grant/response bus
//   Response:      resp_valid one-cycle pulse with resp_rdata, resp_rd,
//                  resp_we and resp_err (00 ok, 01 misaligned, 10 illegal,
//                  11 timeout)
//   TIMEOUT_CYCLES bounds the wait for gnt or rvalid (0 disables it);
//   CNT_W must satisfy 2**CNT_W > TIMEOUT_CYCLES.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  mem_ctrl,
   input  logic        is_load,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [4:0]  rd_addr,
   lsu_if.master       dmem,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [4:0]  resp_rd,
   output logic        resp_we,
   output logic [1:0]  resp_err
);

   localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   lsu_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic             op_we;
   logic [2:0]       op_funct3;
   logic [1:0]       op_addr_lo;
   logic [4:0]       op_rd;

   logic [2:0]  req_funct3;
   logic        req_we;
   logic        accept;
   logic        expired;
   logic [3:0]  req_be;
   logic [31:0] req_wdata_rep;
   logic        req_misaligned;
   logic        req_illegal;
   logic [31:0] ld_data;

   assign req_funct3 = mem_ctrl[MC_F3_MSB:MC_F3_LSB];
   assign req_we     = mem_ctrl[MC_WE_BIT];
   assign accept     = req_valid & req_ready & (req_we | is_load);
   // Counter holds the number of cycles already waited; this is the last one.
   assign expired    = TO_EN && (cnt == TO_LAST);

   lsu_align u_align (
      .req_funct3  (req_funct3),
      .req_we      (req_we),
      .req_addr_lo (addr[1:0]),
      .req_wdata   (wdata),
      .be          (req_be),
      .wdata_rep   (req_wdata_rep),
      .misaligned  (req_misaligned),
      .illegal     (req_illegal),
      .ld_funct3   (op_funct3),
      .ld_addr_lo  (op_addr_lo),
      .ld_rdata    (dmem.dmem_rdata),
      .ld_data     (ld_data)
   );

   // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         cnt             <= '0;
         op_we           <= 1'b0;
         op_funct3       <= '0;
         op_addr_lo      <= '0;
         op_rd           <= '0;
         req_ready       <= 1'b1;
         dmem.dmem_req   <= 1'b0;
         dmem.dmem_we    <= 1'b0;
         dmem.dmem_addr  <= '0;
         dmem.dmem_be    <= '0;
         dmem.dmem_wdata <= '0;
         resp_valid      <= 1'b0;
         resp_rdata      <= '0;
         resp_rd         <= '0;
         resp_we         <= 1'b0;
         resp_err        <= ERR_OK;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  req_ready  <= 1'b0;
                  op_we      <= req_we;
                  op_funct3  <= req_funct3;
                  op_addr_lo <= addr[1:0];
                  op_rd      <= rd_addr;
                  if (req_illegal || req_misaligned) begin
                     // Reject without touching memory.
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= req_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
                  end else begin
                     state           <= S_REQ;
                     cnt             <= '0;
                     dmem.dmem_req   <= 1'b1;
                     dmem.dmem_we    <= req_we;
                     dmem.dmem_addr  <= {addr[31:2], 2'b00};
                     dmem.dmem_be    <= req_be;
                     dmem.dmem_wdata <= req_we ? req_wdata_rep : '0;
                  end
               end
            end

            S_REQ: begin
               if (dmem.dmem_gnt || expired) begin
                  dmem.dmem_req   <= 1'b0;
                  dmem.dmem_we    <= 1'b0;
                  dmem.dmem_addr  <= '0;
                  dmem.dmem_be    <= '0;
                  dmem.dmem_wdata <= '0;
               end
               if (dmem.dmem_gnt) begin
                  if (op_we) begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= ERR_OK;
                  end else begin
                     state <= S_WAIT_R;
                     cnt   <= '0;
                  end
               end else if (expired) begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= ERR_TIMEOUT;
               end else if (TO_EN) begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_WAIT_R: begin
               if (dmem.dmem_rvalid) begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= ld_data;
                  resp_rd    <= op_rd;
                  resp_we    <= (op_rd != 5'd0);
                  resp_err   <= ERR_OK;
               end else if (expired) begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= ERR_TIMEOUT;
               end else if (TO_EN) begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_RESP: begin
               state      <= S_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_rdata <= '0;
               resp_rd    <= '0;
               resp_we    <= 1'b0;
               resp_err   <= ERR_OK;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Cycle numbering: the accept edge closes cycle 0.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  mem_ctrl;
   logic        is_load;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [4:0]  rd_addr;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic        resp_we;
   logic [1:0]  resp_err;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   lsu_if dmem ();

   load_store_unit #(.TIMEOUT_CYCLES(255), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .mem_ctrl   (mem_ctrl),
      .is_load    (is_load),
      .addr       (addr),
      .wdata      (wdata),
      .rd_addr    (rd_addr),
      .dmem       (dmem.master),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_rd    (resp_rd),
      .resp_we    (resp_we),
      .resp_err   (resp_err)
   );

   // Present one op for a single accept edge, then scramble the inputs and
   // return at the falling edge of cycle 1.
   task automatic drive_op(input logic [2:0] f3, input logic we, input logic ld,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
      @(negedge clk);
      req_valid = 1'b1;
      mem_ctrl  = {f3, we};
      is_load   = ld;
      addr      = a;
      wdata     = wd;
      rd_addr   = rd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      mem_ctrl  = 4'hF;
      is_load   = 1'b1;
      addr      = 32'hFFFF_FFFF;
      wdata     = 32'hFFFF_FFFF;
      rd_addr   = 5'h1F;
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_total++;
      if ({req_ready, resp_valid, dmem.dmem_req, resp_we} !== 4'b1000)
         $display("FAIL reset_ctrl: ready/rv/req/we=%b expected 1000",
                  {req_ready, resp_valid, dmem.dmem_req, resp_we});
      else n_pass++;
      n_total++;
      if ({resp_rdata, resp_rd, resp_err, dmem.dmem_be} !== 43'd0)
         $display("FAIL reset_data: rdata=%h rd=%0d err=%b be=%b expected all 0",
                  resp_rdata, resp_rd, resp_err, dmem.dmem_be);
      else n_pass++;
   endtask

   task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd, input int gnt_delay);
      drive_op(f3, 1'b1, 1'b0, a, wd, 5'd9);
      for (int c = 0; c <= gnt_delay; c++) begin
         n_total++;
         if ({dmem.dmem_req, dmem.dmem_we, req_ready, resp_valid} !== 4'b1100 ||
             dmem.dmem_addr !== {a[31:2], 2'b00} || dmem.dmem_be !== exp_be ||
             dmem.dmem_wdata !== exp_wd)
            $display("FAIL %s_bus c%0d: req/we/rdy/rv=%b addr=%h be=%b wd=%h expected 1100 %h %b %h",
                     name, c + 1, {dmem.dmem_req, dmem.dmem_we, req_ready, resp_valid},
                     dmem.dmem_addr, dmem.dmem_be, dmem.dmem_wdata, {a[31:2], 2'b00}, exp_be, exp_wd);
         else n_pass++;
         if (c == gnt_delay) dmem.dmem_gnt = 1'b1;
         @(negedge clk);
      end
      dmem.dmem_gnt = 1'b0;
      n_total++;
      if ({resp_valid, resp_we, resp_err, resp_rd, dmem.dmem_req} !== {1'b1, 1'b0, 2'b00, 5'd0, 1'b0})
         $display("FAIL %s_resp: rv=%b we=%b err=%b rd=%0d req=%b expected rv=1 we=0 err=00 rd=0 req=0",
                  name, resp_valid, resp_we, resp_err, resp_rd, dmem.dmem_req);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({resp_valid, req_ready} !== 2'b01)
         $display("FAIL %s_after: rv/ready=%b expected 01", name, {resp_valid, req_ready});
      else n_pass++;
   endtask

   task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [4:0] rd, input logic [31:0] mem_word,
                            input logic [31:0] exp_data);
      drive_op(f3, 1'b0, 1'b1, a, 32'h0, rd);
      n_total++;
      if ({dmem.dmem_req, dmem.dmem_we} !== 2'b10 || dmem.dmem_addr !== {a[31:2], 2'b00})
         $display("FAIL %s_req: req/we=%b addr=%h expected 10 %h",
                  name, {dmem.dmem_req, dmem.dmem_we}, dmem.dmem_addr, {a[31:2], 2'b00});
      else n_pass++;
      dmem.dmem_gnt = 1'b1;
      @(negedge clk);
      dmem.dmem_gnt    = 1'b0;
      dmem.dmem_rvalid = 1'b1;
      dmem.dmem_rdata  = mem_word;
      n_total++;
      if ({resp_valid, dmem.dmem_req} !== 2'b00)
         $display("FAIL %s_wait: rv/req=%b expected 00", name, {resp_valid, dmem.dmem_req});
      else n_pass++;
      @(negedge clk);
      dmem.dmem_rvalid = 1'b0;
      dmem.dmem_rdata  = 32'h5A5A_5A5A;
      n_total++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp_data || resp_rd !== rd ||
          resp_we !== (rd != 5'd0) || resp_err !== 2'b00)
         $display("FAIL %s_resp: rv=%b data=%h rd=%0d we=%b err=%b expected 1 %h %0d %b 00",
                  name, resp_valid, resp_rdata, resp_rd, resp_we, resp_err,
                  exp_data, rd, (rd != 5'd0));
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({resp_valid, req_ready} !== 2'b01)
         $display("FAIL %s_after: rv/ready=%b expected 01", name, {resp_valid, req_ready});
      else n_pass++;
   endtask

   task automatic test_error(input string name, input logic [2:0] f3, input logic we,
                             input logic ld, input logic [31:0] a, input logic [1:0] exp_err);
      drive_op(f3, we, ld, a, 32'h1234_5678, 5'd4);
      n_total++;
      if (resp_valid !== 1'b1 || resp_err !== exp_err || dmem.dmem_req !== 1'b0 ||
          resp_we !== 1'b0 || resp_rdata !== 32'd0)
         $display("FAIL %s_resp: rv=%b err=%b req=%b we=%b data=%h expected 1 %b 0 0 0",
                  name, resp_valid, resp_err, dmem.dmem_req, resp_we, resp_rdata, exp_err);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({resp_valid, req_ready, dmem.dmem_req} !== 3'b010)
         $display("FAIL %s_after: rv/ready/req=%b expected 010",
                  name, {resp_valid, req_ready, dmem.dmem_req});
      else n_pass++;
   endtask

   task automatic test_ignored();
      drive_op(3'b010, 1'b0, 1'b0, 32'h4000, 32'h0, 5'd1);
      n_total++;
      if ({req_ready, dmem.dmem_req, resp_valid} !== 3'b100)
         $display("FAIL ignored_op: ready/req/rv=%b expected 100",
                  {req_ready, dmem.dmem_req, resp_valid});
      else n_pass++;
   endtask

   task automatic test_timeout();
      int req_cycles = 0;
      int resp_cyc   = -1;
      drive_op(3'b010, 1'b0, 1'b1, 32'h3000, 32'h0, 5'd3);
      for (int c = 1; c <= 400; c++) begin
         if (resp_valid === 1'b1) begin
            resp_cyc = c;
            break;
         end
         if (dmem.dmem_req === 1'b1) req_cycles++;
         @(negedge clk);
      end
      n_total++;
      if (resp_cyc != 256 || req_cycles != 255)
         $display("FAIL timeout_latency: resp cycle=%0d req cycles=%0d expected 256 and 255",
                  resp_cyc, req_cycles);
      else n_pass++;
      n_total++;
      if (resp_err !== 2'b11 || resp_we !== 1'b0 || dmem.dmem_req !== 1'b0)
         $display("FAIL timeout_resp: err=%b we=%b req=%b expected 11 0 0",
                  resp_err, resp_we, dmem.dmem_req);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({resp_valid, req_ready} !== 2'b01)
         $display("FAIL timeout_after: rv/ready=%b expected 01", {resp_valid, req_ready});
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      drive_op(3'b010, 1'b0, 1'b1, 32'h5000, 32'h0, 5'd6);
      dmem.dmem_gnt = 1'b1;
      @(negedge clk);
      dmem.dmem_gnt = 1'b0;
      n_total++;
      if (req_ready !== 1'b0)
         $display("FAIL rstmid_busy: ready=%b expected 0", req_ready);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({req_ready, dmem.dmem_req, resp_valid, resp_we} !== 4'b1000)
         $display("FAIL rstmid_async: ready/req/rv/we=%b expected 1000",
                  {req_ready, dmem.dmem_req, resp_valid, resp_we});
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      dmem.dmem_rvalid = 1'b1;
      dmem.dmem_rdata  = 32'hCAFE_F00D;
      @(negedge clk);
      dmem.dmem_rvalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         n_total++;
         if ({resp_valid, req_ready, dmem.dmem_req} !== 3'b010)
            $display("FAIL rstmid_late_rvalid c%0d: rv/ready/req=%b expected 010",
                     c, {resp_valid, req_ready, dmem.dmem_req});
         else n_pass++;
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n            = 1'b0;
      req_valid        = 1'b0;
      mem_ctrl         = 4'h0;
      is_load          = 1'b0;
      addr             = 32'h0;
      wdata            = 32'h0;
      rd_addr          = 5'd0;
      dmem.dmem_gnt    = 1'b0;
      dmem.dmem_rvalid = 1'b0;
      dmem.dmem_rdata  = 32'h0;
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();

      test_store("sb",    3'b000, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 0);
      test_store("sh",    3'b001, 32'h0000_1002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, 2);
      test_store("sw",    3'b010, 32'h0000_1004, 32'h1122_3344, 4'b1111, 32'h1122_3344, 0);

      test_load("lb",  3'b000, 32'h0000_2002, 5'd10, 32'h1280_FF34, 32'hFFFF_FF80);
      test_load("lbu", 3'b100, 32'h0000_2002, 5'd10, 32'h1280_FF34, 32'h0000_0080);
      test_load("lh",  3'b001, 32'h0000_2002, 5'd11, 32'h8001_1234, 32'hFFFF_8001);
      test_load("lhu", 3'b101, 32'h0000_2002, 5'd11, 32'h8001_1234, 32'h0000_8001);
      test_load("lh0", 3'b001, 32'h0000_2000, 5'd12, 32'h8001_7234, 32'h0000_7234);
      test_load("lw_x0", 3'b010, 32'h0000_2004, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

      test_error("lh_misaligned", 3'b001, 1'b0, 1'b1, 32'h0000_2001, 2'b01);
      test_error("sw_misaligned", 3'b010, 1'b1, 1'b0, 32'h0000_2002, 2'b01);
      test_error("ld_illegal",    3'b011, 1'b0, 1'b1, 32'h0000_2000, 2'b10);
      test_error("st_illegal",    3'b100, 1'b1, 1'b0, 32'h0000_2000, 2'b10);

      test_ignored();
      test_timeout();
      test_reset_mid();
      test_load("lb_after_rst", 3'b000, 32'h0000_2001, 5'd7, 32'h0000_7F00, 32'h0000_007F);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage consuming the control word produced by the main decoder.
  - Memory control: {funct3, we}.
  - Load select: derived from result_src == 01.
  - ALU-computed address and rs2 store data.
- Drives a single-outstanding data-memory request/grant/response interface.
- Generates byte enables and lane-replicated write data.
- Returns sign- or zero-extended load data plus the destination register to writeback.
- Stalls the pipeline through req_ready while a transaction is in flight.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for dmem_gnt or dmem_rvalid before aborting; 0 disables the timeout
CNT_W, 8, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  memory op presented this cycle
req_ready  out  1  unit can accept (high only in IDLE)
mem_ctrl  in  4  {funct3, we}; we=1 store, we=0 with is_load=1 load
is_load  in  1  load op (decoder result_src == 01)
addr  in  32  effective byte address
wdata  in  32  store data (rs2)
rd_addr  in  5  load destination register
dmem_req  out  1  memory request, held until granted
dmem_we  out  1  write enable
dmem_addr  out  32  word address ({addr[31:2], 2'b00})
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read data
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data (0 for stores/errors)
resp_rd  out  5  destination register (0 for stores)
resp_we  out  1  writeback enable (successful load only)
resp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout

Behaviour:
- Reset: all outputs 0 except req_ready = 1.
  - State returns to IDLE and the counter clears.
  - Reset applies asynchronously, including mid-transaction; an in-flight request is dropped with no response.
- Accept condition: req_valid & req_ready & (we | is_load).
  - req_valid with neither we nor is_load is ignored; the unit stays in IDLE.
- Operation, address, data and rd are registered on accept; inputs are don't-care afterwards.
- FSM states: IDLE, REQ, WAIT_R, RESP.
  - IDLE -> REQ on a legal, aligned accept.
  - IDLE -> RESP on an illegal or misaligned accept, with the error code set; no memory access is made.
  - REQ: dmem_req = 1 with dmem_we, addr, be and wdata stable until dmem_gnt.
  - REQ with gnt: store -> RESP; load -> WAIT_R.
  - WAIT_R on dmem_rvalid: capture dmem_rdata, extend it, -> RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then -> IDLE; req_ready rises in the following cycle.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is an illegal-funct3 error.
- Alignment: H needs addr[0] = 0; W needs addr[1:0] = 00. Violation gives a misaligned error.
- Byte enables:
  - B: 0001 << addr[1:0].
  - H: 0011 << {addr[1], 1'b0}.
  - W: 1111.
- Write data:
  - B: {4{wdata[7:0]}}.
  - H: {2{wdata[15:0]}}.
  - W: wdata.
- Load extraction: select the byte or halfword lane using the registered addr[1:0].
  - LB/LH sign-extend from the selected lane's MSB.
  - LBU/LHU zero-extend.
- Minimum latency (accept cycle = 0):
  - Store with immediate grant: resp_valid at cycle 2.
  - Load with gnt at cycle 1 and rvalid at cycle 2: resp_valid at cycle 3.
  - Error: resp_valid at cycle 1.
- Timeout counter:
  - Clears on entry to REQ and WAIT_R; increments each cycle spent waiting.
  - Reaching TIMEOUT_CYCLES -> RESP with timeout error, dmem_req deasserted, resp_we = 0.
- dmem_rvalid outside WAIT_R is ignored; dmem_gnt outside REQ is ignored.
- rvalid in the same cycle as gnt is not sampled; memory returns data at least one cycle after grant.
- Success responses:
  - Store: resp_we = 0, resp_rd = 0.
  - Load: resp_we = 1 only if rd_addr != 0.

Decomposition:
- lsu_pkg holds:
  - funct3 enum (LB/LH/LW/LBU/LHU, SB/SH/SW).
  - FSM state enum.
  - resp_err enum.
  - The 4-bit mem_ctrl field positions.
- Sub-module lsu_align, purely combinational:
  - Store side: funct3 + addr[1:0] + wdata -> be, wdata, misaligned, illegal.
  - Load side: funct3 + addr[1:0] + rdata -> extended load data.
- The FSM and timeout counter stay in load_store_unit.

Test Plan:
- SB, addr = 0x1003, wdata = 0x000000A5, gnt at cycle 1 -> dmem_be = 1000, dmem_wdata = 0xA5A5A5A5, dmem_addr = 0x1000, resp_valid at cycle 2 with resp_we = 0, err = 00.
- LB, addr = 0x2002, rdata = 0x1280FF34 -> resp_rdata = 0xFFFFFF80, resp_we = 1, resp_rd echoed; the same access as LBU -> 0x00000080.
- LH, addr = 0x2002, rdata = 0x8001_1234 -> 0xFFFF8001; LH at 0x2001 -> resp_valid at cycle 1, err = 01, dmem_req never asserted.
- mem_ctrl funct3 = 011 load -> err = 10 at cycle 1; gnt withheld for 255 cycles on LW -> err = 11, dmem_req drops, req_ready high after RESP.
- rst_n pulled low while in WAIT_R -> outputs immediately 0 with req_ready = 1, no resp_valid; a late dmem_rvalid after release is ignored.
